// File: rtl/segre_mshr_file_if.sv
// Request and MMU handshake bundle for the data-side miss-status holding register file.
// The master drives requests, grants and fills. The slave (the MSHR file) answers them.
interface segre_mshr_file_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ID_W   = 2
);
  logic              req_valid_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic              req_is_store_i;
  logic              req_ready_o;
  logic              req_merged_o;
  logic [ID_W-1:0]   req_entry_o;

  logic              mmu_req_o;
  logic [ADDR_W-1:0] mmu_addr_o;
  logic [ID_W-1:0]   mmu_entry_o;
  logic              mmu_gnt_i;
  logic              mmu_fill_valid_i;
  logic [ID_W-1:0]   mmu_fill_entry_i;

  modport master (
    output req_valid_i, req_addr_i, req_is_store_i, mmu_gnt_i, mmu_fill_valid_i,
    output mmu_fill_entry_i,
    input  req_ready_o, req_merged_o, req_entry_o, mmu_req_o, mmu_addr_o, mmu_entry_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, req_is_store_i, mmu_gnt_i, mmu_fill_valid_i,
    input  mmu_fill_entry_i,
    output req_ready_o, req_merged_o, req_entry_o, mmu_req_o, mmu_addr_o, mmu_entry_o
  );
endinterface

// File: rtl/segre_mshr_file.sv
// Miss-status holding register file. It tracks outstanding line misses and merges same-line
// requests. It issues line requests round-robin to the MMU and reports completed fills.
module segre_mshr_file #(
  parameter int unsigned  NUM_ENTRIES = 4,
  parameter int unsigned  ADDR_W      = 32,
  parameter int unsigned  LINE_OFF_W  = 4,
  parameter int unsigned  MAX_MERGE   = 4,
  localparam int unsigned ID_W        = $clog2(NUM_ENTRIES),
  localparam int unsigned CNT_W       = $clog2(MAX_MERGE + 1),
  localparam int unsigned OCC_W       = $clog2(NUM_ENTRIES + 1)
) (
  input  logic              clk_i,
  input  logic              rsn_i,
  segre_mshr_file_if.slave  bus,
  input  logic [ADDR_W-1:0] lookup_addr_i,
  output logic              lookup_hit_o,
  output logic              fill_valid_o,
  output logic [ADDR_W-1:0] fill_addr_o,
  output logic [CNT_W-1:0]  fill_count_o,
  output logic              fill_has_store_o,
  input  logic              flush_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [OCC_W-1:0]  outstanding_o,
  output logic              protocol_err_o
);
  localparam int unsigned TAG_W = ADDR_W - LINE_OFF_W;

  localparam logic [1:0] StFree = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StPend = 2'd2;

  logic [1:0]             r_state     [NUM_ENTRIES];
  logic [TAG_W-1:0]       r_tag       [NUM_ENTRIES];
  logic [CNT_W-1:0]       r_count     [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] r_has_store;
  logic [ID_W-1:0]        r_rr_ptr;
  logic                   r_lock;
  logic [ID_W-1:0]        r_lock_idx;
  logic                   r_fill_valid;
  logic [ADDR_W-1:0]      r_fill_addr;
  logic [CNT_W-1:0]       r_fill_count;
  logic                   r_fill_store;
  logic                   r_perr;

  logic [TAG_W-1:0]       w_req_tag, w_lookup_tag, w_issue_tag;
  logic [NUM_ENTRIES-1:0] w_fill_hit;
  logic                   w_fill_ok, w_fill_err;
  logic                   w_any_free, w_match_found, w_lookup_hit;
  logic [ID_W-1:0]        w_free_idx, w_match_idx;
  logic [CNT_W-1:0]       w_match_cnt;
  logic [OCC_W-1:0]       w_outstanding;
  logic [ADDR_W-1:0]      w_fill_addr;
  logic [CNT_W-1:0]       w_fill_count;
  logic                   w_fill_store;
  logic                   w_rr_found, w_issue_valid, w_gnt;
  logic [ID_W-1:0]        w_rr_idx, w_issue_idx;
  logic                   w_req_ok, w_merge, w_alloc;
  logic                   w_unused;

  assign w_req_tag    = bus.req_addr_i[ADDR_W-1:LINE_OFF_W];
  assign w_lookup_tag = lookup_addr_i[ADDR_W-1:LINE_OFF_W];
  assign w_unused     = ^{bus.req_addr_i[LINE_OFF_W-1:0], lookup_addr_i[LINE_OFF_W-1:0]};

  // Only a fill aimed at a PENDING entry is legal; anything else is a protocol error.
  always_comb begin
    w_fill_hit = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_fill_hit[i] = bus.mmu_fill_valid_i && (bus.mmu_fill_entry_i == ID_W'(i)) &&
                      (r_state[i] == StPend);
    end
  end
  assign w_fill_ok  = |w_fill_hit;
  assign w_fill_err = bus.mmu_fill_valid_i && !w_fill_ok;

  always_comb begin
    w_any_free    = 1'b0;
    w_free_idx    = '0;
    w_match_found = 1'b0;
    w_match_idx   = '0;
    w_match_cnt   = '0;
    w_lookup_hit  = 1'b0;
    w_outstanding = '0;
    w_fill_addr   = '0;
    w_fill_count  = '0;
    w_fill_store  = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (r_state[i] == StFree) begin
        if (!w_any_free) begin
          w_any_free = 1'b1;
          w_free_idx = ID_W'(i);
        end
      end else begin
        w_outstanding = w_outstanding + OCC_W'(1);
        if (r_tag[i] == w_lookup_tag) w_lookup_hit = 1'b1;
        // An entry retiring this cycle can no longer absorb requests.
        if (!w_match_found && (r_tag[i] == w_req_tag) && !w_fill_hit[i]) begin
          w_match_found = 1'b1;
          w_match_idx   = ID_W'(i);
          w_match_cnt   = r_count[i];
        end
      end
      if (w_fill_hit[i]) begin
        w_fill_addr  = {r_tag[i], {LINE_OFF_W{1'b0}}};
        w_fill_count = r_count[i];
        w_fill_store = r_has_store[i];
      end
    end
  end

  always_comb begin
    int unsigned k;
    k          = 0;
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    for (int unsigned i = 1; i <= NUM_ENTRIES; i++) begin
      k = (32'(r_rr_ptr) + i) % NUM_ENTRIES;
      if (!w_rr_found && (r_state[ID_W'(k)] == StWait)) begin
        w_rr_found = 1'b1;
        w_rr_idx   = ID_W'(k);
      end
    end
  end

  // Once presented, the issue choice is locked so address and entry stay stable until granted.
  assign w_issue_valid   = r_lock | w_rr_found;
  assign w_issue_idx     = r_lock ? r_lock_idx : w_rr_idx;
  assign w_issue_tag     = r_tag[w_issue_idx];
  assign w_gnt           = w_issue_valid & bus.mmu_gnt_i;
  assign bus.mmu_req_o   = w_issue_valid;
  assign bus.mmu_entry_o = w_issue_valid ? w_issue_idx : '0;
  assign bus.mmu_addr_o  = w_issue_valid ? {w_issue_tag, {LINE_OFF_W{1'b0}}} : '0;

  assign w_req_ok         = bus.req_valid_i & ~flush_i;
  assign w_merge          = w_req_ok & w_match_found & (w_match_cnt < CNT_W'(MAX_MERGE));
  assign w_alloc          = w_req_ok & ~w_match_found & w_any_free;
  assign bus.req_ready_o  = w_merge | w_alloc;
  assign bus.req_merged_o = w_merge;
  assign bus.req_entry_o  = w_merge ? w_match_idx : (w_alloc ? w_free_idx : '0);

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_state[i] <= StFree;
        r_tag[i]   <= '0;
        r_count[i] <= '0;
      end
      r_has_store <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        // Grant beats a concurrent flush; fill and grant never target the same entry.
        if (w_fill_hit[i]) begin
          r_state[i] <= StFree;
        end else if (w_gnt && (w_issue_idx == ID_W'(i))) begin
          r_state[i] <= StPend;
        end else if (flush_i && (r_state[i] == StWait)) begin
          r_state[i] <= StFree;
        end else if (w_alloc && (w_free_idx == ID_W'(i))) begin
          r_state[i] <= StWait;
        end
        if (w_alloc && (w_free_idx == ID_W'(i))) begin
          r_tag[i]       <= w_req_tag;
          r_count[i]     <= CNT_W'(1);
          r_has_store[i] <= bus.req_is_store_i;
        end else if (w_merge && (w_match_idx == ID_W'(i))) begin
          r_count[i]     <= r_count[i] + CNT_W'(1);
          r_has_store[i] <= r_has_store[i] | bus.req_is_store_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      r_rr_ptr     <= '0;
      r_lock       <= 1'b0;
      r_lock_idx   <= '0;
      r_fill_valid <= 1'b0;
      r_fill_addr  <= '0;
      r_fill_count <= '0;
      r_fill_store <= 1'b0;
      r_perr       <= 1'b0;
    end else begin
      if (w_gnt) r_rr_ptr <= w_issue_idx;
      if (w_gnt || flush_i) begin
        r_lock <= 1'b0;
      end else if (w_issue_valid) begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_issue_idx;
      end
      r_fill_valid <= w_fill_ok;
      r_fill_addr  <= w_fill_addr;
      r_fill_count <= w_fill_count;
      r_fill_store <= w_fill_store;
      r_perr       <= r_perr | w_fill_err;
    end
  end

  assign lookup_hit_o     = w_lookup_hit;
  assign fill_valid_o     = r_fill_valid;
  assign fill_addr_o      = r_fill_addr;
  assign fill_count_o     = r_fill_count;
  assign fill_has_store_o = r_fill_store;
  assign full_o           = ~w_any_free;
  assign empty_o          = (w_outstanding == '0);
  assign outstanding_o    = w_outstanding;
  assign protocol_err_o   = r_perr;
endmodule

// File: tb/tb_segre_mshr_file.sv
// Directed bench for segre_mshr_file: a per-cycle vector table plus hand-written corner sequences.
module tb_segre_mshr_file;
  localparam int unsigned NE = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned NV = 15;

  typedef struct {
    logic        v;
    logic [31:0] addr;
    logic        st;
    logic        gnt;
    logic        fv;
    logic [1:0]  fe;
    logic        fl;
    logic        rdy;
    logic        mrg;
    logic [1:0]  ent;
    logic        mreq;
    logic [31:0] maddr;
    logic [1:0]  ment;
    logic        fvo;
    logic [31:0] faddr;
    logic [2:0]  fcnt;
    logic        fst;
    logic [2:0]  outst;
    logic        full;
    logic        empty;
  } vec_t;

  logic          clk_i = 1'b0;
  logic          rsn_i;
  logic [AW-1:0] lookup_addr_i;
  logic          lookup_hit_o;
  logic          fill_valid_o;
  logic [AW-1:0] fill_addr_o;
  logic [2:0]    fill_count_o;
  logic          fill_has_store_o;
  logic          flush_i;
  logic          full_o;
  logic          empty_o;
  logic [2:0]    outstanding_o;
  logic          protocol_err_o;

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs [NV];

  segre_mshr_file_if #(.ADDR_W(AW), .ID_W(2)) bus ();

  segre_mshr_file #(
    .NUM_ENTRIES(NE),
    .ADDR_W     (AW),
    .LINE_OFF_W (4),
    .MAX_MERGE  (4)
  ) dut (
    .clk_i           (clk_i),
    .rsn_i           (rsn_i),
    .bus             (bus),
    .lookup_addr_i   (lookup_addr_i),
    .lookup_hit_o    (lookup_hit_o),
    .fill_valid_o    (fill_valid_o),
    .fill_addr_o     (fill_addr_o),
    .fill_count_o    (fill_count_o),
    .fill_has_store_o(fill_has_store_o),
    .flush_i         (flush_i),
    .full_o          (full_o),
    .empty_o         (empty_o),
    .outstanding_o   (outstanding_o),
    .protocol_err_o  (protocol_err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic vec_t mk(
    input logic v, input logic [31:0] addr, input logic st, input logic gnt, input logic fv,
    input logic [1:0] fe, input logic fl, input logic rdy, input logic mrg, input logic [1:0] ent,
    input logic mreq, input logic [31:0] maddr, input logic [1:0] ment, input logic fvo,
    input logic [31:0] faddr, input logic [2:0] fcnt, input logic fst, input logic [2:0] outst,
    input logic full, input logic empty);
    vec_t r;
    r.v = v; r.addr = addr; r.st = st; r.gnt = gnt; r.fv = fv; r.fe = fe; r.fl = fl;
    r.rdy = rdy; r.mrg = mrg; r.ent = ent; r.mreq = mreq; r.maddr = maddr; r.ment = ment;
    r.fvo = fvo; r.faddr = faddr; r.fcnt = fcnt; r.fst = fst; r.outst = outst;
    r.full = full; r.empty = empty;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic st, input logic g,
                       input logic fv, input logic [1:0] fe, input logic fl);
    bus.req_valid_i      = v;
    bus.req_addr_i       = a;
    bus.req_is_store_i   = st;
    bus.mmu_gnt_i        = g;
    bus.mmu_fill_valid_i = fv;
    bus.mmu_fill_entry_i = fe;
    flush_i              = fl;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic req_chk(input string nm, input logic rdy, input logic mrg, input logic [1:0] e);
    chk({nm, ".ready"}, 32'(bus.req_ready_o), 32'(rdy));
    chk({nm, ".merged"}, 32'(bus.req_merged_o), 32'(mrg));
    chk({nm, ".entry"}, 32'(bus.req_entry_o), 32'(e));
  endtask

  task automatic mmu_chk(input string nm, input logic rq, input logic [31:0] a,
                         input logic [1:0] e);
    chk({nm, ".mmu_req"}, 32'(bus.mmu_req_o), 32'(rq));
    chk({nm, ".mmu_addr"}, bus.mmu_addr_o, a);
    chk({nm, ".mmu_entry"}, 32'(bus.mmu_entry_o), 32'(e));
  endtask

  task automatic do_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    rsn_i = 1'b0;
    tick();
    rsn_i = 1'b1;
  endtask

  initial begin
    // Cycle-by-cycle table: inputs during the cycle and the outputs seen in that same cycle.
    //            v addr          st g fv fe fl  rdy m e  mreq maddr         me fvo faddr     c st
    //            outst full empty
    vecs[0]  = mk(1, 32'h10000044, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0,        0, 0, 32'h0, 0, 0,
                  0, 0, 1);
    vecs[1]  = mk(0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h10000040, 0, 0, 32'h0, 0, 0,
                  1, 0, 0);
    vecs[2]  = mk(0, 32'h0,        0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h10000040, 0, 0, 32'h0, 0, 0,
                  1, 0, 0);
    vecs[3]  = mk(0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0, 0, 0,
                  1, 0, 0);
    vecs[4]  = mk(1, 32'h10000048, 1, 0, 0, 0, 0, 1, 1, 0, 0, 32'h0,        0, 0, 32'h0, 0, 0,
                  1, 0, 0);
    vecs[5]  = mk(0, 32'h0,        0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0, 0, 0,
                  1, 0, 0);
    vecs[6]  = mk(0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 1, 32'h10000040,
                  2, 1, 0, 0, 1);
    vecs[7]  = mk(1, 32'h100,      0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0,        0, 0, 32'h0, 0, 0,
                  0, 0, 1);
    vecs[8]  = mk(1, 32'h200,      0, 0, 0, 0, 0, 1, 0, 1, 1, 32'h100,      0, 0, 32'h0, 0, 0,
                  1, 0, 0);
    vecs[9]  = mk(1, 32'h300,      0, 1, 0, 0, 0, 1, 0, 2, 1, 32'h100,      0, 0, 32'h0, 0, 0,
                  2, 0, 0);
    vecs[10] = mk(1, 32'h400,      0, 1, 0, 0, 0, 1, 0, 3, 1, 32'h200,      1, 0, 32'h0, 0, 0,
                  3, 0, 0);
    vecs[11] = mk(0, 32'h0,        0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h300,      2, 0, 32'h0, 0, 0,
                  4, 1, 0);
    vecs[12] = mk(1, 32'h500,      0, 1, 1, 2, 0, 0, 0, 0, 1, 32'h400,      3, 0, 32'h0, 0, 0,
                  4, 1, 0);
    vecs[13] = mk(1, 32'h500,      0, 0, 0, 0, 0, 1, 0, 2, 0, 32'h0,        0, 1, 32'h300,
                  1, 0, 3, 0, 0);
    vecs[14] = mk(0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h500,      2, 0, 32'h0, 0, 0,
                  4, 1, 0);

    lookup_addr_i = '0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    rsn_i = 1'b0;
    #12;
    chk("reset.empty", 32'(empty_o), 32'd1);
    chk("reset.full", 32'(full_o), 32'd0);
    chk("reset.outstanding", 32'(outstanding_o), 32'd0);
    chk("reset.fill_valid", 32'(fill_valid_o), 32'd0);
    chk("reset.perr", 32'(protocol_err_o), 32'd0);
    chk("reset.mmu_req", 32'(bus.mmu_req_o), 32'd0);
    @(posedge clk_i);
    #1;
    rsn_i = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].v, vecs[i].addr, vecs[i].st, vecs[i].gnt, vecs[i].fv, vecs[i].fe,
            vecs[i].fl);
      #1;
      req_chk($sformatf("v%0d", i), vecs[i].rdy, vecs[i].mrg, vecs[i].ent);
      mmu_chk($sformatf("v%0d", i), vecs[i].mreq, vecs[i].maddr, vecs[i].ment);
      chk($sformatf("v%0d.fill_valid", i), 32'(fill_valid_o), 32'(vecs[i].fvo));
      chk($sformatf("v%0d.fill_addr", i), fill_addr_o, vecs[i].faddr);
      chk($sformatf("v%0d.fill_count", i), 32'(fill_count_o), 32'(vecs[i].fcnt));
      chk($sformatf("v%0d.fill_store", i), 32'(fill_has_store_o), 32'(vecs[i].fst));
      chk($sformatf("v%0d.outstanding", i), 32'(outstanding_o), 32'(vecs[i].outst));
      chk($sformatf("v%0d.full", i), 32'(full_o), 32'(vecs[i].full));
      chk($sformatf("v%0d.empty", i), 32'(empty_o), 32'(vecs[i].empty));
      tick();
    end

    // Merge saturation, lookup, and a request hitting a line retiring in the same cycle.
    do_reset();
    drive(1'b1, 32'h20000000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0); #1;
    req_chk("sat1", 1'b1, 1'b0, 2'd0); tick();
    drive(1'b1, 32'h20000004, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0); #1;
    req_chk("sat2", 1'b1, 1'b1, 2'd0);
    mmu_chk("sat2", 1'b1, 32'h20000000, 2'd0); tick();
    drive(1'b1, 32'h20000008, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    lookup_addr_i = 32'h2000000C; #1;
    req_chk("sat3", 1'b1, 1'b1, 2'd0);
    chk("lookup.hit", 32'(lookup_hit_o), 32'd1); tick();
    drive(1'b1, 32'h2000000C, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    lookup_addr_i = 32'h20000010; #1;
    req_chk("sat4", 1'b1, 1'b1, 2'd0);
    chk("lookup.miss", 32'(lookup_hit_o), 32'd0); tick();
    drive(1'b1, 32'h20000000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0); #1;
    req_chk("sat5", 1'b0, 1'b0, 2'd0); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0); #1;
    mmu_chk("sat_gnt", 1'b1, 32'h20000000, 2'd0); tick();
    drive(1'b1, 32'h20000004, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0); #1;
    req_chk("sat_refill", 1'b1, 1'b0, 2'd1); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0); #1;
    chk("sat.fill_valid", 32'(fill_valid_o), 32'd1);
    chk("sat.fill_addr", fill_addr_o, 32'h20000000);
    chk("sat.fill_count", 32'(fill_count_o), 32'd4);
    chk("sat.fill_store", 32'(fill_has_store_o), 32'd1);
    chk("sat.outstanding", 32'(outstanding_o), 32'd1);
    mmu_chk("sat_next", 1'b1, 32'h20000000, 2'd1); tick();
    chk("sat.fill_pulse", 32'(fill_valid_o), 32'd0);

    // Flush drops waiting entries but keeps pending ones; a grant beats a same-cycle flush.
    do_reset();
    drive(1'b1, 32'h30000000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0); #1;
    req_chk("fl_a", 1'b1, 1'b0, 2'd0); tick();
    drive(1'b1, 32'h30001000, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0); #1;
    req_chk("fl_b", 1'b1, 1'b0, 2'd1);
    mmu_chk("fl_b", 1'b1, 32'h30000000, 2'd0); tick();
    drive(1'b1, 32'h30002000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1); #1;
    req_chk("fl_c", 1'b0, 1'b0, 2'd0);
    mmu_chk("fl_c", 1'b1, 32'h30001000, 2'd1);
    chk("fl_c.outstanding", 32'(outstanding_o), 32'd2); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    lookup_addr_i = 32'h30001000; #1;
    mmu_chk("fl_d", 1'b0, 32'h0, 2'd0);
    chk("fl_d.outstanding", 32'(outstanding_o), 32'd1);
    chk("fl_d.lookup", 32'(lookup_hit_o), 32'd0); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0); #1;
    chk("fl_f.fill_valid", 32'(fill_valid_o), 32'd1);
    chk("fl_f.fill_addr", fill_addr_o, 32'h30000000);
    chk("fl_f.fill_count", 32'(fill_count_o), 32'd1);
    chk("fl_f.empty", 32'(empty_o), 32'd1); tick();
    drive(1'b1, 32'h30003000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0); #1;
    req_chk("fl_g", 1'b1, 1'b0, 2'd0); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1); #1;
    mmu_chk("fl_h", 1'b1, 32'h30003000, 2'd0); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0); #1;
    chk("fl_i.outstanding", 32'(outstanding_o), 32'd1);
    mmu_chk("fl_i", 1'b0, 32'h0, 2'd0);

    // Illegal fills set the sticky error without touching state; async reset clears all.
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0); tick();
    drive(1'b1, 32'h40000000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0); #1;
    chk("perr_a.perr", 32'(protocol_err_o), 32'd1);
    chk("perr_a.fill_valid", 32'(fill_valid_o), 32'd0);
    chk("perr_a.outstanding", 32'(outstanding_o), 32'd1);
    req_chk("perr_a", 1'b1, 1'b0, 2'd1); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0); #1;
    mmu_chk("perr_b", 1'b1, 32'h40000000, 2'd1); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0); #1;
    chk("perr_c.fill_valid", 32'(fill_valid_o), 32'd0);
    chk("perr_c.outstanding", 32'(outstanding_o), 32'd2);
    chk("perr_c.perr", 32'(protocol_err_o), 32'd1);
    mmu_chk("perr_c", 1'b1, 32'h40000000, 2'd1);
    #2;
    rsn_i = 1'b0;
    #1;
    chk("async.perr", 32'(protocol_err_o), 32'd0);
    chk("async.empty", 32'(empty_o), 32'd1);
    chk("async.outstanding", 32'(outstanding_o), 32'd0);
    chk("async.mmu_req", 32'(bus.mmu_req_o), 32'd0);
    tick();
    rsn_i = 1'b1;
    tick();
    chk("post_reset.perr", 32'(protocol_err_o), 32'd0);
    chk("post_reset.full", 32'(full_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
